// File: rtl/mux_ser_pkg.sv
// Shared types and select-index helpers for the mux serializer.
// The optional parity slot is enabled with MUX_SER_PARITY_EN.
package mux_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // -1 truncates to all ones, i.e. WIDTH-1, because WIDTH is a power of 2.
    function automatic int sel_first(input int msb_first);
        return (msb_first != 0) ? -1 : 0;
    endfunction

    function automatic int sel_last(input int width, input int msb_first);
        return (msb_first != 0) ? 0 : width - 1;
    endfunction

endpackage

// File: rtl/mux_serializer_bit_sel.sv
// Combinational WIDTH:1 bit-select mux.
// Picks data[sel]; sel spans exactly the word because WIDTH is a power of 2.
module bit_sel #(
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SEL_W-1:0] sel,
    output logic             sel_bit
);

    assign sel_bit = data[sel];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-in/serial-out stage driving a WIDTH:1 bit-select mux.
// Define MUX_SER_PARITY_EN to append an even-parity bit to each word.
module mux_serializer
    import mux_ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    localparam int SEL_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done
);

    localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(sel_first(MSB_FIRST));
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(sel_last(WIDTH, MSB_FIRST));
    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold;
    logic [SEL_W-1:0] sel_step;
    logic             is_last;
    logic             load;
    logic             data_bit;

    assign is_last  = (sel == SEL_LAST);
    assign sel_step = (MSB_FIRST != 0) ? sel - SEL_ONE : sel + SEL_ONE;
    assign load     = in_valid && in_ready;

    bit_sel #(
        .WIDTH(WIDTH)
    ) u_bit_sel (
        .data   (hold),
        .sel    (sel),
        .sel_bit(data_bit)
    );

`ifdef MUX_SER_PARITY_EN
    logic par_bit;

    assign par_bit = ^hold;
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = data_bit;
                busy      = 1'b1;
                if (is_last) begin
`ifdef MUX_SER_PARITY_EN
                    state_nxt = ST_PAR;
`else
                    // Accepting here keeps back-to-back words bubble-free.
                    done      = 1'b1;
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef MUX_SER_PARITY_EN
            ST_PAR: begin
                ser_valid = 1'b1;
                ser_out   = par_bit;
                busy      = 1'b1;
                done      = 1'b1;
                in_ready  = 1'b1;
                state_nxt = in_valid ? ST_SHIFT : ST_IDLE;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hold  <= '0;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                hold <= in_data;
                sel  <= SEL_FIRST;
            end else if (state == ST_SHIFT && !is_last) begin
                sel <= sel_step;
            end
        end
    end

endmodule

// File: tb/tb_mux_serializer.sv
// Bench for mux_serializer: LSB-first and MSB-first instances share stimulus
// and are checked each cycle against a queue-based word-stream model.
module tb_mux_serializer;

`ifdef MUX_SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic       b_l;
        logic       b_m;
        logic [2:0] s_l;
        logic [2:0] s_m;
        logic       done;
        logic       last;
    } rec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;

    logic       rdy_l, sv_l, so_l, busy_l, done_l;
    logic       rdy_m, sv_m, so_m, busy_m, done_m;
    logic [2:0] sel_l, sel_m;

    int   vectors;
    int   miscompares;
    rec_t q[$];
    logic [2:0] idle_sel_l;
    logic [2:0] idle_sel_m;

    mux_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_l),
        .in_data(in_data), .ser_out(so_l), .ser_valid(sv_l), .sel(sel_l),
        .busy(busy_l), .done(done_l)
    );

    mux_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m),
        .in_data(in_data), .ser_out(so_m), .ser_valid(sv_m), .sel(sel_m),
        .busy(busy_m), .done(done_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        rec_t r;
        for (int i = 0; i < 8; i++) begin
            r.b_l  = w[i];
            r.b_m  = w[7-i];
            r.s_l  = 3'(i);
            r.s_m  = 3'(7 - i);
            r.done = (i == 7) && !PAR;
            r.last = r.done;
            q.push_back(r);
        end
        if (PAR) begin
            r.b_l  = ^w;
            r.b_m  = ^w;
            r.s_l  = 3'd7;
            r.s_m  = 3'd0;
            r.done = 1'b1;
            r.last = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rdy_l"}, 8'(rdy_l), 8'd1);
        chk({tag, "_rdy_m"}, 8'(rdy_m), 8'd1);
        chk({tag, "_sv_l"}, 8'(sv_l), 8'd0);
        chk({tag, "_sv_m"}, 8'(sv_m), 8'd0);
        chk({tag, "_so_l"}, 8'(so_l), 8'd0);
        chk({tag, "_so_m"}, 8'(so_m), 8'd0);
        chk({tag, "_sel_l"}, 8'(sel_l), 8'd0);
        chk({tag, "_sel_m"}, 8'(sel_m), 8'd0);
        chk({tag, "_busy_l"}, 8'(busy_l), 8'd0);
        chk({tag, "_done_l"}, 8'(done_l), 8'd0);
        chk({tag, "_done_m"}, 8'(done_m), 8'd0);
    endtask

    task automatic model_clear();
        q.delete();
        idle_sel_l = 3'd0;
        idle_sel_m = 3'd0;
    endtask

    // Called just after a falling edge; returns after the next one.
    task automatic cycle(input logic v, input logic [7:0] d);
        logic       act;
        logic       e_rdy;
        rec_t       h;
        in_valid = v;
        in_data  = d;
        #1;
        act   = (q.size() != 0);
        e_rdy = !act || q[0].last;
        if (act) begin
            h = q[0];
        end else begin
            h.b_l  = 1'b0;
            h.b_m  = 1'b0;
            h.s_l  = idle_sel_l;
            h.s_m  = idle_sel_m;
            h.done = 1'b0;
            h.last = 1'b0;
        end
        chk("in_ready_l", 8'(rdy_l), 8'(e_rdy));
        chk("in_ready_m", 8'(rdy_m), 8'(e_rdy));
        chk("ser_valid_l", 8'(sv_l), 8'(act));
        chk("ser_valid_m", 8'(sv_m), 8'(act));
        chk("ser_out_l", 8'(so_l), 8'(h.b_l));
        chk("ser_out_m", 8'(so_m), 8'(h.b_m));
        chk("sel_l", 8'(sel_l), 8'(h.s_l));
        chk("sel_m", 8'(sel_m), 8'(h.s_m));
        chk("busy_l", 8'(busy_l), 8'(act));
        chk("busy_m", 8'(busy_m), 8'(act));
        chk("done_l", 8'(done_l), 8'(h.done));
        chk("done_m", 8'(done_m), 8'(h.done));
        if (act) begin
            idle_sel_l = h.s_l;
            idle_sel_m = h.s_m;
            void'(q.pop_front());
        end
        if (v && e_rdy) begin
            push_word(d);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 8'h00);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        rst_n       = 1'b0;
        model_clear();

        // Reset and idle.
        @(negedge clk);
        chk_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00);
        end

        // Single word, both bit orders (and parity slot when enabled).
        cycle(1'b1, 8'b1010_1011);
        drain();

        // Back-to-back with in_valid held high.
        cycle(1'b1, 8'hF0);
        for (int i = 0; i < 8 + int'(PAR); i++) begin
            cycle(1'b1, 8'h0F);
        end
        drain();

        // Offer 8'hFF mid-word; only the done cycle may accept it.
        cycle(1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00);
        end
        for (int i = 0; i < 5 + int'(PAR); i++) begin
            cycle(1'b1, 8'hFF);
        end
        drain();

        // Reset while sel=4 of 8'hA5, then restart with 8'h3C.
        cycle(1'b1, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00);
        end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h3C);
        drain();

        cycle(1'b1, 8'h03);
        drain();

        // Randomized offers.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
